// File: rtl/switch_debounce_ctrl_if.sv
// CPU-side register bus of the DIP switch controller (memorio chip-select slot).
// The master drives the strobes; the slave returns read data and a level interrupt.
interface switch_debounce_ctrl_if;
    logic        switchcs;
    logic [1:0]  switchaddr;
    logic        switchread;
    logic        switchwrite;
    logic [15:0] switchwdata;
    logic [15:0] switchrdata;
    logic        switch_irq;

    modport master (
        output switchcs, switchaddr, switchread, switchwrite, switchwdata,
        input  switchrdata, switch_irq
    );

    modport slave (
        input  switchcs, switchaddr, switchread, switchwrite, switchwdata,
        output switchrdata, switch_irq
    );
endinterface

// File: rtl/switch_debounce_ctrl.sv
// Debounced 24-bit DIP switch image with sticky W1C change flags and a level interrupt.
// Reads return the pre-edge value one falling edge later; the bus never stalls.
module switch_debounce_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int TICK_W   = 17
) (
    input  logic                  clk,
    input  logic                  switrst,
    input  logic [23:0]           switch_i,
    switch_debounce_ctrl_if.slave bus
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [23:0]       sync1_q, sync1_d;
    logic [23:0]       sync2_q, sync2_d;
    logic [23:0]       h0_q, h0_d;
    logic [23:0]       h1_q, h1_d;
    logic [23:0]       stable_q, stable_d;
    logic [23:0]       chg_q, chg_d;
    logic              ien_q, ien_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [15:0]       rdata_q, rdata_d;

    logic              tick;
    logic [23:0]       accept;
    logic [23:0]       clr;
    logic              wr_en;
    logic              rd_en;
    logic              unused_wdata;

    assign unused_wdata = ^bus.switchwdata[14:8];

    always_comb begin
        sync1_d    = switch_i;
        sync2_d    = sync1_q;
        h0_d       = h0_q;
        h1_d       = h1_q;
        accept     = '0;
        clr        = '0;
        ien_d      = ien_q;
        rdata_d    = rdata_q;
        wr_en      = bus.switchcs && bus.switchwrite;
        rd_en      = bus.switchcs && bus.switchread;

        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

        // The oldest history stage never takes part in acceptance, so only two are kept.
        if (tick) begin
            accept = ~(sync2_q ^ h0_q) & ~(sync2_q ^ h1_q) & (sync2_q ^ stable_q);
            h0_d   = sync2_q;
            h1_d   = h0_q;
        end
        stable_d = stable_q ^ accept;

        if (wr_en) begin
            case (bus.switchaddr)
                2'b01: clr = {8'h00, bus.switchwdata};
                2'b11: begin
                    clr   = {bus.switchwdata[7:0], 16'h0000};
                    ien_d = bus.switchwdata[15];
                end
                default: ;
            endcase
        end
        // A flag being set on the same edge as its clear must survive.
        chg_d = (chg_q & ~clr) | accept;

        if (rd_en) begin
            case (bus.switchaddr)
                2'b00: rdata_d = stable_q[15:0];
                2'b10: rdata_d = {8'h00, stable_q[23:16]};
                2'b01: rdata_d = chg_q[15:0];
                2'b11: rdata_d = {ien_q, 7'b0000000, chg_q[23:16]};
                default: rdata_d = rdata_q;
            endcase
        end
    end

    always_ff @(negedge clk or posedge switrst) begin
        if (switrst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            h0_q       <= '0;
            h1_q       <= '0;
            stable_q   <= '0;
            chg_q      <= '0;
            ien_q      <= 1'b0;
            tick_cnt_q <= '0;
            rdata_q    <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            h0_q       <= h0_d;
            h1_q       <= h1_d;
            stable_q   <= stable_d;
            chg_q      <= chg_d;
            ien_q      <= ien_d;
            tick_cnt_q <= tick_cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.switchrdata = rdata_q;
    assign bus.switch_irq  = ien_q & (|chg_q);

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Randomised scoreboard bench for switch_debounce_ctrl with a tick-sample reference model.
module tb_switch_debounce_ctrl;

    localparam int TDIV = 4;

    logic        clk = 1'b0;
    logic        switrst;
    logic [23:0] switch_i;

    switch_debounce_ctrl_if bus ();

    switch_debounce_ctrl #(.TICK_DIV(TDIV), .TICK_W(3)) dut (
        .clk      (clk),
        .switrst  (switrst),
        .switch_i (switch_i),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;
    bit rd_seen = 0;
    logic [15:0] exp_q[$];

    // Reference model: switch levels as seen at each falling edge, reduced to tick samples.
    int          m_edge = 0;
    logic [23:0] raw_old = '0, raw_new = '0;
    logic [23:0] ts[$] = '{24'h0, 24'h0};
    logic [23:0] m_stable = '0, m_chg = '0;
    logic        m_ien = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [23:0] s2;
        logic [23:0] newly;
        if (switrst) begin
            m_edge = 0; raw_old = '0; raw_new = '0;
            ts = '{24'h0, 24'h0};
            m_stable = '0; m_chg = '0; m_ien = 1'b0;
        end else begin
            s2 = raw_old;
            raw_old = raw_new;
            raw_new = switch_i;
            m_edge++;
            newly = '0;
            if (m_edge % TDIV == 0) begin
                for (int i = 0; i < 24; i++)
                    if (s2[i] == ts[1][i] && s2[i] == ts[0][i] && s2[i] != m_stable[i])
                        newly[i] = 1'b1;
                m_stable = m_stable ^ newly;
                void'(ts.pop_front());
                ts.push_back(s2);
            end
            if (bus.switchcs && bus.switchwrite) begin
                if (bus.switchaddr == 2'b01) m_chg = m_chg & ~{8'h00, bus.switchwdata};
                if (bus.switchaddr == 2'b11) begin
                    m_chg = m_chg & ~{bus.switchwdata[7:0], 16'h0000};
                    m_ien = bus.switchwdata[15];
                end
            end
            m_chg = m_chg | newly;
        end
        rd_seen <= !switrst && bus.switchcs && bus.switchread;
    end

    function automatic logic [15:0] exp_read(input logic [1:0] a);
        case (a)
            2'b00:   return m_stable[15:0];
            2'b10:   return {8'h00, m_stable[23:16]};
            2'b01:   return m_chg[15:0];
            default: return {m_ien, 7'b0, m_chg[23:16]};
        endcase
    endfunction

    // True when the coming falling edge will accept a change on switch bit 3.
    function automatic bit pred3();
        if ((m_edge + 1) % TDIV != 0) return 1'b0;
        return raw_old[3] == ts[1][3] && raw_old[3] == ts[0][3] && raw_old[3] != m_stable[3];
    endfunction

    // Monitor: compares each registered read and the interrupt level.
    always @(posedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rd_underflow: got read with empty queue at %0t", $time);
            end else begin
                check("rdata", {16'h0, bus.switchrdata}, {16'h0, exp_q.pop_front()});
            end
        end
        if (chk_en && !switrst)
            check("irq", {31'h0, bus.switch_irq}, {31'h0, m_ien & (|m_chg)});
    end

    task automatic drive(input bit cs, input bit rd, input bit wr,
                         input logic [1:0] a, input logic [15:0] wd);
        @(posedge clk);
        bus.switchcs    = cs;
        bus.switchread  = rd;
        bus.switchwrite = wr;
        bus.switchaddr  = a;
        bus.switchwdata = wd;
        if (cs && rd) exp_q.push_back(exp_read(a));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 2'b00, 16'h0000);
    endtask

    task automatic read_all();
        drive(1, 1, 0, 2'b00, 16'h0);
        drive(1, 1, 0, 2'b10, 16'h0);
        drive(1, 1, 0, 2'b01, 16'h0);
        drive(1, 1, 0, 2'b11, 16'h0);
        idle(1);
    endtask

    task automatic do_reset();
        idle(1);
        @(posedge clk);
        switrst = 1'b1;
        #1;
        check("rst_rdata", {16'h0, bus.switchrdata}, 32'h0);
        check("rst_irq", {31'h0, bus.switch_irq}, 32'h0);
        repeat (2) @(posedge clk);
        switrst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit hit;
        logic [23:0] sw_next;
        int op;

        bus.switchcs = 0; bus.switchread = 0; bus.switchwrite = 0;
        bus.switchaddr = 2'b00; bus.switchwdata = 16'h0;
        switch_i = 24'hFFFFFF;
        switrst  = 1'b1;
        #1;
        check("init_rdata", {16'h0, bus.switchrdata}, 32'h0);
        check("init_irq", {31'h0, bus.switch_irq}, 32'h0);
        repeat (3) @(posedge clk);
        switch_i = 24'h000000;
        switrst  = 1'b0;
        chk_en   = 1'b1;
        read_all();

        // Steady input accepted after three ticks.
        idle(1);
        switch_i = 24'hA51234;
        idle(20);
        read_all();

        // Short glitch on bit 0, then a long hold.
        switch_i = 24'hA51235;
        idle(5);
        switch_i = 24'hA51234;
        idle(20);
        read_all();
        switch_i = 24'hA51235;
        idle(20);
        read_all();

        // Interrupt enable, then clear all flags.
        drive(1, 0, 1, 2'b11, 16'h8000);
        idle(2);
        drive(1, 0, 1, 2'b01, 16'h1235);
        drive(1, 0, 1, 2'b11, 16'h80A5);
        idle(2);
        read_all();

        // Clear chg[3] on the very edge its stable bit changes.
        switch_i = 24'hA5123D;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (pred3()) begin
                drive(1, 0, 1, 2'b01, 16'h0008);
                hit = 1;
            end else begin
                idle(1);
            end
        end
        check("race_hit", {31'h0, hit}, 32'h1);
        idle(1);
        read_all();

        // Reset while a new value is mid-debounce.
        switch_i = 24'h0F0F0F;
        idle(6);
        do_reset();
        drive(1, 1, 0, 2'b00, 16'h0);
        idle(8);
        drive(1, 1, 0, 2'b00, 16'h0);
        idle(6);
        read_all();

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            sw_next = switch_i;
            if ($urandom_range(0, 9) == 0)
                sw_next = switch_i ^ 24'($urandom & $urandom & $urandom);
            op = $urandom_range(0, 6);
            case (op)
                0, 1: idle(1);
                2:    drive(1, 1, 0, 2'($urandom), 16'($urandom));
                3:    drive(1, 0, 1, 2'($urandom), 16'($urandom));
                4:    drive(1, 1, 1, 2'($urandom), 16'($urandom));
                5:    drive(0, 1, 1, 2'($urandom), 16'($urandom));
                default: drive(1, 0, 1, 2'b11, 16'h8000 | 16'($urandom_range(0, 1)));
            endcase
            switch_i = sw_next;
        end
        idle(3);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
